io_timer_port: RTL

Memory-mapped I/O responder on the CPU's Direcciones/Datos/oe bus. It is the slave end of the CPU's I/O accesses.
- Decodes an 8-word window.
- Latches CPU writes; drives read data onto the shared Datos bus.
- Contains a prescaled 16-bit down-counter timer, a 16-bit output port and a synchronized 16-bit input port.
- Raises a one-cycle interrupt request on one line of the CPU's 8-bit interrupt vector.

---
 rtl/io_timer_port.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_timer_port.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer_port
//  Description : Memory-mapped I/O responder on the CPU Direcciones/Datos/oe
//                bus. It decodes an 8-word window and contains:
//                  - a prescaled 16-bit down-counter timer,
//                  - a 16-bit registered output port,
//                  - a 2-flop synchronized 16-bit input port.
//                Timer expiry pulses one bit of the CPU interrupt vector.
//
//  Ports       : clk          system clock, rising edge
//                reset        asynchronous, active-high reset
//                oe           1 = CPU drives Datos (write), 0 = read/idle
//                Direcciones  CPU address
//                Datos        shared data bus, driven only on a selected read
//                port_in      external input pins (asynchronous)
//                port_out     registered output port
//                intr         interrupt vector, only bit IRQ_LINE is used
//
//  Register map (word offset inside the window):
//                0 CTRL   [0] EN, [1] AUTO, [2] IE, [15:8] PRESC
//                1 RELOAD
//                2 COUNT  (write loads counter and clears prescaler)
//                3 STATUS [0] EXP (W1C), [1] CAPF (W1C, capture build only)
//                4 OUT
//                5 IN     (read only, synchronized port_in)
//                6 CAP    (read only, capture build only, else 0)
//                7 reads 0
//
//  Build option: define IO_TIMER_CAPTURE_EN to add the input-capture unit
//                (CAP register, CAPF flag, capture interrupt).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module io_timer_port #(
  parameter logic [15:0] BASE     = 16'hFFF0,
  parameter int unsigned IRQ_LINE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oe,
  input  logic [15:0] Direcciones,
  inout  wire  [15:0] Datos,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic [7:0]  intr
);

  localparam logic [2:0] IRQ_IDX    = IRQ_LINE[2:0];

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_RELOAD = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_OUT    = 3'd4;
  localparam logic [2:0] OFF_IN     = 3'd5;
  localparam logic [2:0] OFF_CAP    = 3'd6;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        sel;
  logic [2:0]  off;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_reload;
  logic        wr_count;
  logic        wr_status;
  logic        wr_out;

  assign sel       = (Direcciones[15:3] == BASE[15:3]);
  assign off       = Direcciones[2:0];
  assign wr        = sel & oe;
  assign wr_ctrl   = wr & (off == OFF_CTRL);
  assign wr_reload = wr & (off == OFF_RELOAD);
  assign wr_count  = wr & (off == OFF_COUNT);
  assign wr_status = wr & (off == OFF_STATUS);
  assign wr_out    = wr & (off == OFF_OUT);

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  logic        en;
  logic        auto_rl;
  logic        ie;
  logic [7:0]  presc;
  logic [15:0] reload;
  logic [15:0] count;
  logic        exp_flag;
  logic [7:0]  pcnt;
  logic [15:0] sync1;
  logic [15:0] sync2;
  logic        irq_q;

  logic        tick;
  logic        expire;
  logic        irq_set;
  logic [15:0] rd_data;

  // Capture-unit view seen by the rest of the block; tied off when the
  // capture unit is not built.
  logic        cap_evt;
  logic        capf_rd;
  logic [15:0] cap_rd;

  // A tick only happens while the timer is enabled; the expiry is the tick
  // that finds the counter already at zero.
  assign tick   = en & (pcnt == presc);
  assign expire = tick & (count == 16'd0);

  // --------------------------------------------------------------------------
  // Prescaler: held at 0 while disabled, restarted by a COUNT write so the
  // freshly loaded value gets a full prescale period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= 8'd0;
    end else if (!en || wr_count || tick) begin
      pcnt <= 8'd0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // CTRL: a bus write wins over the auto-disable on a one-shot expiry.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      presc   <= 8'd0;
    end else if (wr_ctrl) begin
      en      <= Datos[0];
      auto_rl <= Datos[1];
      ie      <= Datos[2];
      presc   <= Datos[15:8];
    end else if (expire && !auto_rl) begin
      en      <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // RELOAD
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload <= 16'd0;
    end else if (wr_reload) begin
      reload <= Datos;
    end
  end

  // --------------------------------------------------------------------------
  // COUNT: bus write beats decrement/reload. A one-shot expiry leaves the
  // counter at zero (no underflow).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (wr_count) begin
      count <= Datos;
    end else if (tick) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (auto_rl) begin
        count <= reload;
      end
    end
  end

  // --------------------------------------------------------------------------
  // STATUS.EXP: sticky, write-1-to-clear, a new expiry wins over the clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_status && Datos[0]) begin
      exp_flag <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out <= 16'd0;
    end else if (wr_out) begin
      port_out <= Datos;
    end
  end

  // --------------------------------------------------------------------------
  // Input port synchronizer (two flops, two-cycle latency)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 16'd0;
      sync2 <= 16'd0;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional input-capture unit
  // --------------------------------------------------------------------------
`ifdef IO_TIMER_CAPTURE_EN
  logic        in0_q;
  logic [15:0] cap;
  logic        capf;

  // Rising edge of the synchronized pin 0.
  assign cap_evt = sync2[0] & ~in0_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in0_q <= 1'b0;
      cap   <= 16'd0;
      capf  <= 1'b0;
    end else begin
      in0_q <= sync2[0];
      if (cap_evt) begin
        cap  <= count;
        capf <= 1'b1;
      end else if (wr_status && Datos[1]) begin
        capf <= 1'b0;
      end
    end
  end

  assign capf_rd = capf;
  assign cap_rd  = cap;
`else
  assign cap_evt = 1'b0;
  assign capf_rd = 1'b0;
  assign cap_rd  = 16'd0;
`endif

  // --------------------------------------------------------------------------
  // Interrupt: one-cycle pulse in the cycle following the triggering edge.
  // --------------------------------------------------------------------------
  assign irq_set = (expire | cap_evt) & ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_set;
    end
  end

  always_comb begin
    intr          = 8'd0;
    intr[IRQ_IDX] = irq_q;
  end

  // --------------------------------------------------------------------------
  // Read mux and bus driver. The block never drives while the CPU does.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data = 16'd0;
    case (off)
      OFF_CTRL:   rd_data = {presc, 5'd0, ie, auto_rl, en};
      OFF_RELOAD: rd_data = reload;
      OFF_COUNT:  rd_data = count;
      OFF_STATUS: rd_data = {14'd0, capf_rd, exp_flag};
      OFF_OUT:    rd_data = port_out;
      OFF_IN:     rd_data = sync2;
      OFF_CAP:    rd_data = cap_rd;
      default:    rd_data = 16'd0;
    endcase
  end

  assign Datos = (sel && !oe) ? rd_data : 16'bz;

endmodule
`default_nettype wire
